// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
// Command byte layout: address in [7:3], write flag in [1].
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int STATUS_REG_DEF = 25;
    localparam int IEN_REG_DEF    = 26;
    localparam int NUM_REGS       = 32;
    localparam int DIR_BIT        = 1;
    localparam int ADDR_MSB       = 7;
    localparam int ADDR_LSB       = 3;

    // Status bits are set from the local side and cleared by writing ones over SPI.
    function automatic logic [7:0] status_w1c(input logic [7:0] cur, input logic [7:0] clr);
        return cur & ~clr;
    endfunction

    function automatic logic [7:0] status_set(input logic [7:0] cur, input logic [7:0] set);
        return cur | set;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous pin.
// Edges are suppressed until the chain has flushed after reset, so a pin already low is not seen as a fall.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   vld_q;

    // Synchronizer chain, previous-value flop and post-reset flush tracker.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
            vld_q  <= {vld_q[STAGES-1:0], 1'b1};
        end
    end

    assign rise_o = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 peripheral exposing a 32 x 8 register file with MAX3421E-style command bytes,
// plus a local read/write port and a status/enable interrupt.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int STATUS_REG  = STATUS_REG_DEF,
    parameter int IEN_REG     = IEN_REG_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       spi_SCLK,
    input  logic       spi_MOSI,
    input  logic       spi_SS_n,
    output logic       spi_MISO,
    output logic       spi_MISO_oe,
    input  logic [4:0] loc_addr,
    input  logic       loc_wr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       xfer_active,
    output logic       irq_n
);

    localparam logic [4:0] STATUS_A = 5'(STATUS_REG);
    localparam logic [4:0] IEN_A    = 5'(IEN_REG);

    logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i(Clk), .reset_i(Reset), .pin_i(spi_SCLK),
        .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk_i(Clk), .reset_i(Reset), .pin_i(spi_SS_n),
        .rise_o(ss_rise_s), .fall_o(ss_fall_s)
    );

    // MOSI only needs a level; its timing relative to SCLK matches the SCLK chain.
    always_ff @(posedge Clk) begin
        if (Reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_MOSI};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [6:0] shift_in_q;
    logic [7:0] shift_out_q, tx_next_q;
    logic [4:0] addr_q;
    logic       dir_q, oe_q;
    logic       wr_strobe_q;
    logic [4:0] wr_addr_q;
    logic [7:0] wr_data_q, loc_rdata_q;
    logic       irq_n_q;
    logic [7:0] regs_q [NUM_REGS];

    logic [7:0] rx_byte;
    logic       byte_done, spi_wr, loc_wr_en;
    logic [7:0] spi_wdata_d, loc_wdata_d;

    assign rx_byte   = {shift_in_q, mosi_s};
    assign byte_done = sclk_rise_s && (bitcnt_q == 3'd7) && (state_q != IDLE) && !ss_rise_s;
    assign spi_wr    = byte_done && (state_q == DATA) && dir_q;
    assign loc_wr_en = loc_wr && !(spi_wr && (loc_addr == addr_q));

    // Write data after the status register's set/clear semantics are applied.
    always_comb begin
        spi_wdata_d = rx_byte;
        loc_wdata_d = loc_wdata;
        if (addr_q == STATUS_A) spi_wdata_d = status_w1c(regs_q[STATUS_A], rx_byte);
        else                    spi_wdata_d = rx_byte;
        if (loc_addr == STATUS_A) loc_wdata_d = status_set(regs_q[STATUS_A], loc_wdata);
        else                      loc_wdata_d = loc_wdata;
    end

    // Transfer FSM with its shift registers, bit counter and write-strobe outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 8'h00;
            tx_next_q   <= 8'h00;
            addr_q      <= 5'd0;
            dir_q       <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
        end else begin
            wr_strobe_q <= 1'b0;
            if (ss_rise_s) begin
                state_q <= IDLE;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ss_fall_s) begin
                            state_q     <= CMD;
                            shift_out_q <= regs_q[STATUS_A];
                            bitcnt_q    <= 3'd0;
                            oe_q        <= 1'b1;
                        end
                    end
                    CMD, DATA: begin
                        if (sclk_rise_s) begin
                            shift_in_q <= rx_byte[6:0];
                            bitcnt_q   <= bitcnt_q + 3'd1;
                        end
                        if (byte_done && state_q == CMD) begin
                            addr_q    <= rx_byte[ADDR_MSB:ADDR_LSB];
                            dir_q     <= rx_byte[DIR_BIT];
                            tx_next_q <= rx_byte[DIR_BIT] ? 8'h00 : regs_q[rx_byte[ADDR_MSB:ADDR_LSB]];
                            state_q   <= DATA;
                        end else if (byte_done && dir_q) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= addr_q;
                            wr_data_q   <= rx_byte;
                            tx_next_q   <= 8'h00;
                        end else if (byte_done) begin
                            tx_next_q <= regs_q[addr_q];
                        end
                        // The first fall after a completed byte hands over the next byte to send.
                        if (sclk_fall_s) begin
                            if (bitcnt_q == 3'd0) shift_out_q <= tx_next_q;
                            else                  shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file; an SPI write to the same address beats the local write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            if (spi_wr)    regs_q[addr_q]   <= spi_wdata_d;
            if (loc_wr_en) regs_q[loc_addr] <= loc_wdata_d;
        end
    end

    // Local read port and interrupt output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            loc_rdata_q <= 8'h00;
            irq_n_q     <= 1'b1;
        end else begin
            loc_rdata_q <= regs_q[loc_addr];
            irq_n_q     <= ~|(regs_q[STATUS_A] & regs_q[IEN_A]);
        end
    end

    assign spi_MISO    = oe_q & shift_out_q[7];
    assign spi_MISO_oe = oe_q;
    assign xfer_active = oe_q;
    assign loc_rdata   = loc_rdata_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign irq_n       = irq_n_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: drives SPI mode-0 transfers and the local port,
// checking outputs against hand-computed values.
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam int HALF = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       spi_SCLK = 1'b0, spi_MOSI = 1'b0, spi_SS_n = 1'b1;
    logic       spi_MISO, spi_MISO_oe;
    logic [4:0] loc_addr = 5'd0;
    logic       loc_wr = 1'b0;
    logic [7:0] loc_wdata = 8'h00;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       xfer_active, irq_n;

    int n_checks = 0;
    int n_fail   = 0;
    int n_str    = 0;
    logic [4:0] s_addr [4];
    logic [7:0] s_data [4];

    spi_reg_responder dut (
        .Clk(Clk), .Reset(Reset),
        .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
        .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe),
        .loc_addr(loc_addr), .loc_wr(loc_wr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .xfer_active(xfer_active), .irq_n(irq_n)
    );

    always #5 Clk = ~Clk;

    // Record every write strobe; slots are relative to the running count.
    always @(negedge Clk) begin
        if (wr_strobe) begin
            s_addr[n_str % 4] = wr_addr;
            s_data[n_str % 4] = wr_data;
            n_str = n_str + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_MOSI = b;
        wait_clk(HALF);
        spi_SCLK = 1'b1;
        r = spi_MISO;
        wait_clk(HALF);
        spi_SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic ss_low();
        spi_SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        spi_SS_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_wr    = 1'b1;
        wait_clk(1);
        loc_wr    = 1'b0;
        wait_clk(1);
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        loc_addr = a;
        wait_clk(2);
        d = loc_rdata;
    endtask

    initial begin
        logic [7:0] rx, rd;
        logic       r;
        int         base;

        // 1: reset values, then SCLK activity with SS_n high
        wait_clk(4);
        Reset = 1'b0;
        wait_clk(1);
        check("rst_miso", spi_MISO, 0);
        check("rst_oe", spi_MISO_oe, 0);
        check("rst_rdata", loc_rdata, 8'h00);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_xfer", xfer_active, 0);
        check("rst_irq_n", irq_n, 1);
        base = n_str;
        for (int i = 0; i < 16; i++) spi_bit(1'b1, r);
        wait_clk(HALF);
        check("idle_xfer", xfer_active, 0);
        check("idle_oe", spi_MISO_oe, 0);
        check("idle_strobes", n_str - base, 0);

        // 2: SPI write 0x5A to register 17
        base = n_str;
        ss_low();
        check("t2_active", xfer_active, 1);
        spi_byte(8'h8A, rx);
        check("t2_status_byte", rx, 8'h00);
        spi_byte(8'h5A, rx);
        ss_high();
        check("t2_strobes", n_str - base, 1);
        check("t2_wr_addr", s_addr[base % 4], 5'd17);
        check("t2_wr_data", s_data[base % 4], 8'h5A);
        loc_read(5'd17, rd);
        check("t2_reg17", rd, 8'h5A);

        // 3: local writes, then SPI read of register 3
        loc_write(5'd3, 8'hA5);
        loc_write(5'd25, 8'h81);
        ss_low();
        spi_byte(8'h18, rx);
        check("t3_status_byte", rx, 8'h81);
        spi_byte(8'h00, rx);
        check("t3_reg3_byte", rx, 8'hA5);
        ss_high();

        // 4: interrupt raised by enable, cleared by SPI write-1-to-clear
        loc_write(5'd26, 8'h80);
        wait_clk(3);
        check("t4_irq_asserted", irq_n, 0);
        base = n_str;
        ss_low();
        spi_byte(8'hCA, rx);
        check("t4_status_byte", rx, 8'h81);
        spi_byte(8'h80, rx);
        ss_high();
        loc_read(5'd25, rd);
        check("t4_reg25", rd, 8'h01);
        check("t4_irq_cleared", irq_n, 1);
        check("t4_strobes", n_str - base, 1);
        check("t4_wr_addr", s_addr[base % 4], 5'd25);

        // 5: two data bytes reuse the same address
        base = n_str;
        ss_low();
        spi_byte(8'h8A, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        ss_high();
        check("t5_strobes", n_str - base, 2);
        check("t5_data0", s_data[base % 4], 8'h11);
        check("t5_data1", s_data[(base + 1) % 4], 8'h22);
        check("t5_addr1", s_addr[(base + 1) % 4], 5'd17);
        loc_read(5'd17, rd);
        check("t5_reg17", rd, 8'h22);

        // 6a: SS_n rises after four data bits
        base = n_str;
        ss_low();
        spi_byte(8'h8A, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        ss_high();
        check("t6a_strobes", n_str - base, 0);
        check("t6a_xfer", xfer_active, 0);
        loc_read(5'd17, rd);
        check("t6a_reg17", rd, 8'h22);

        // 6b: Reset mid-byte with SS_n held low; no transfer until SS_n goes high then low
        base = n_str;
        ss_low();
        spi_byte(8'h8A, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        Reset = 1'b1;
        wait_clk(2);
        Reset = 1'b0;
        wait_clk(1);
        check("t6b_rst_xfer", xfer_active, 0);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        spi_byte(8'h8A, rx);
        spi_byte(8'h77, rx);
        check("t6b_no_restart", xfer_active, 0);
        ss_high();
        check("t6b_strobes", n_str - base, 0);
        check("t6b_irq_n", irq_n, 1);
        loc_read(5'd17, rd);
        check("t6b_reg17", rd, 8'h00);

        // 6c: a fresh transfer after the reset works
        base = n_str;
        ss_low();
        spi_byte(8'h8A, rx);
        spi_byte(8'h3C, rx);
        ss_high();
        check("t6c_strobes", n_str - base, 1);
        check("t6c_wr_data", s_data[base % 4], 8'h3C);
        ss_low();
        spi_byte(8'h88, rx);
        check("t6c_status_byte", rx, 8'h00);
        spi_byte(8'h00, rx);
        check("t6c_read17", rx, 8'h3C);
        ss_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
